// File: rtl/regfile_rat_pkg.sv
// Shared types and constants for the register file / rename table slice.
// Holds the width constants, the tag-zero constant, the commit tag-clear
// payload and the update-source priority encoding (flush > recover > normal).
// NCKPT must be a power of 2 so head/tail wrap by plain overflow.
package regfile_rat_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREG    = 32;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned NRD     = 4;
    localparam int unsigned NCOMMIT = 2;
    localparam int unsigned NCKPT   = 4;

    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned CK_W  = $clog2(NCKPT);
    localparam int unsigned CNT_W = CK_W + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [CK_W-1:0]  ck_id_t;
    typedef logic [CNT_W-1:0] ck_cnt_t;
    typedef logic [XLEN-1:0]  xval_t;

    // Tag 0 means "no in-flight producer, architectural value is current".
    localparam tag_t TAG_ZERO = '0;

    // One tag per architectural register.
    typedef tag_t [NREG-1:0] tag_tbl_t;

    // Commit request as seen by the tag tables (value is handled separately).
    typedef struct packed {
        logic valid;
        idx_t rd;
        tag_t tag;
    } clr_t;

    // Which source feeds the tag table this cycle.
    typedef enum logic [1:0] {
        UPD_NORMAL  = 2'd0,
        UPD_RECOVER = 2'd1,
        UPD_FLUSH   = 2'd2
    } upd_sel_e;

    function automatic upd_sel_e upd_select(input logic flush, input logic rec);
        if (flush) return UPD_FLUSH;
        if (rec)   return UPD_RECOVER;
        return UPD_NORMAL;
    endfunction

endpackage

// File: rtl/rat_ckpt_store.sv
// Checkpoint store: NCKPT in-order snapshots of the tag table managed as a
// FIFO (head = oldest, tail = next slot to fill, count disambiguates full
// from empty). Commits retire matching tags inside every live snapshot.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rdy           - global enable; state holds when low
//   sel           - update source for this cycle (normal / recover / flush)
//   alloc_req     - snapshot request (rejected when full or not normal)
//   free_req      - release oldest slot (ignored when empty)
//   rec_id        - slot to recover to when sel == UPD_RECOVER
//   snap_in       - post-update tag table to capture on allocate
//   clr           - commit tag-clear requests, port 0 oldest
//   rec_snap      - stored snapshot at rec_id
//   ck_id         - slot the next allocate will use
//   ck_full       - no free slot
module rat_ckpt_store
    import regfile_rat_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  upd_sel_e                 sel,
    input  logic                     alloc_req,
    input  logic                     free_req,
    input  ck_id_t                   rec_id,
    input  tag_tbl_t                 snap_in,
    input  clr_t [NCOMMIT-1:0]       clr,
    output tag_tbl_t                 rec_snap,
    output ck_id_t                   ck_id,
    output logic                     ck_full
);

    tag_tbl_t ck_q [NCKPT];
    tag_tbl_t ck_d [NCKPT];
    ck_id_t   head_q, head_d;
    ck_id_t   tail_q, tail_d;
    ck_cnt_t  count_q, count_d;

    logic   do_alloc;
    logic   do_free;
    ck_id_t offs;
    ck_id_t rec_offs;
    ck_cnt_t rec_count;

    assign ck_id    = tail_q;
    assign ck_full  = (count_q == CNT_W'(NCKPT));
    assign rec_snap = ck_q[rec_id];

    // Next-state: commit clears, then FIFO pointer update by source.
    always_comb begin
        ck_d      = ck_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        offs      = '0;
        rec_offs  = '0;
        rec_count = '0;
        do_free   = free_req && (count_q != '0);
        do_alloc  = alloc_req && !ck_full && (sel == UPD_NORMAL);

        // A slot is live if its distance from head is below count.
        for (int unsigned c = 0; c < NCKPT; c++) begin
            offs = CK_W'(c) - head_q;
            if (CNT_W'(offs) < count_q) begin
                for (int unsigned p = 0; p < NCOMMIT; p++) begin
                    if (clr[p].valid && (clr[p].rd != '0) &&
                        (ck_d[c][clr[p].rd] == clr[p].tag)) begin
                        ck_d[c][clr[p].rd] = TAG_ZERO;
                    end
                end
            end
        end

        case (sel)
            UPD_FLUSH: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
            UPD_RECOVER: begin
                // Recovered slot stays allocated; everything younger is dropped.
                rec_offs  = rec_id - head_q;
                rec_count = CNT_W'(rec_offs) + CNT_W'(1);
                tail_d    = rec_id + CK_W'(1);
                head_d    = do_free ? head_q + CK_W'(1) : head_q;
                count_d   = do_free ? rec_count - CNT_W'(1) : rec_count;
            end
            default: begin
                if (do_alloc) begin
                    ck_d[tail_q] = snap_in;
                    tail_d       = tail_q + CK_W'(1);
                end
                if (do_free) begin
                    head_d = head_q + CK_W'(1);
                end
                count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_free);
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned c = 0; c < NCKPT; c++) begin
                ck_q[c] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy) begin
            ck_q    <= ck_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file with rename tag table and branch checkpoints.
// Decode reads values/tags through NRD combinational ports with a same-cycle
// commit bypass, renames one destination per cycle, and the ROB retires up to
// NCOMMIT results per cycle. Mispredicts restore a stored tag snapshot.
// Ports:
//   clk, rst, rdy                     - clock, sync active-high reset, enable
//   rd_idx / rd_tag / rd_val          - read ports (combinational)
//   ren_valid / ren_rd / ren_tag      - destination rename
//   cm_valid / cm_rd / cm_tag / cm_val- retirement writes, port 0 oldest
//   ck_alloc / ck_id / ck_full        - snapshot allocate and status
//   ck_free                           - release oldest snapshot
//   rec_valid / rec_id                - mispredict recovery
//   flush_all                         - clear every tag and checkpoint
module regfile_rat
    import regfile_rat_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic [NRD-1:0][IDX_W-1:0]      rd_idx,
    output logic [NRD-1:0][TAG_W-1:0]      rd_tag,
    output logic [NRD-1:0][XLEN-1:0]       rd_val,
    input  logic                           ren_valid,
    input  logic [IDX_W-1:0]               ren_rd,
    input  logic [TAG_W-1:0]               ren_tag,
    input  logic [NCOMMIT-1:0]             cm_valid,
    input  logic [NCOMMIT-1:0][IDX_W-1:0]  cm_rd,
    input  logic [NCOMMIT-1:0][TAG_W-1:0]  cm_tag,
    input  logic [NCOMMIT-1:0][XLEN-1:0]   cm_val,
    input  logic                           ck_alloc,
    output logic [CK_W-1:0]                ck_id,
    output logic                           ck_full,
    input  logic                           ck_free,
    input  logic                           rec_valid,
    input  logic [CK_W-1:0]                rec_id,
    input  logic                           flush_all
);

    xval_t [NREG-1:0] val_q, val_d;
    tag_tbl_t         tag_q, tag_d;
    tag_tbl_t         rec_snap;
    clr_t [NCOMMIT-1:0] clr;
    upd_sel_e         sel;

    assign sel = upd_select(flush_all, rec_valid);

    // Commit requests as tag-clear payloads.
    always_comb begin
        for (int unsigned p = 0; p < NCOMMIT; p++) begin
            clr[p].valid = cm_valid[p];
            clr[p].rd    = cm_rd[p];
            clr[p].tag   = cm_tag[p];
        end
    end

    // Next tag table: base (live or snapshot), commits in order, then rename.
    always_comb begin
        tag_d = (sel == UPD_RECOVER) ? rec_snap : tag_q;
        for (int unsigned p = 0; p < NCOMMIT; p++) begin
            if (cm_valid[p] && (cm_rd[p] != '0) && (tag_d[cm_rd[p]] == cm_tag[p])) begin
                tag_d[cm_rd[p]] = TAG_ZERO;
            end
        end
        if ((sel == UPD_NORMAL) && ren_valid && (ren_rd != '0) && (ren_tag != TAG_ZERO)) begin
            tag_d[ren_rd] = ren_tag;
        end
        if (sel == UPD_FLUSH) begin
            tag_d = '0;
        end
    end

    // Value writes happen on every commit regardless of flush/recover.
    always_comb begin
        val_d = val_q;
        for (int unsigned p = 0; p < NCOMMIT; p++) begin
            if (cm_valid[p] && (cm_rd[p] != '0)) begin
                val_d[cm_rd[p]] = cm_val[p];
            end
        end
    end

    // Read ports with commit bypass; the youngest matching port wins.
    always_comb begin
        for (int unsigned r = 0; r < NRD; r++) begin
            rd_val[r] = val_q[rd_idx[r]];
            rd_tag[r] = tag_q[rd_idx[r]];
            for (int unsigned p = 0; p < NCOMMIT; p++) begin
                if (cm_valid[p] && (cm_rd[p] == rd_idx[r]) &&
                    (cm_tag[p] == tag_q[rd_idx[r]])) begin
                    rd_val[r] = cm_val[p];
                    rd_tag[r] = TAG_ZERO;
                end
            end
            if (rd_idx[r] == '0) begin
                rd_val[r] = '0;
                rd_tag[r] = TAG_ZERO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= '0;
            tag_q <= '0;
        end else if (rdy) begin
            val_q <= val_d;
            tag_q <= tag_d;
        end
    end

    rat_ckpt_store u_ckpt (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .sel       (sel),
        .alloc_req (ck_alloc),
        .free_req  (ck_free),
        .rec_id    (rec_id),
        .snap_in   (tag_d),
        .clr       (clr),
        .rec_snap  (rec_snap),
        .ck_id     (ck_id),
        .ck_full   (ck_full)
    );

endmodule

// File: tb/tb_regfile_rat.sv
// Directed bench for regfile_rat: rename/commit/bypass, checkpoints, recovery
// and flush, each checked against hand-computed values.
module tb_regfile_rat;
    import regfile_rat_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst;
    logic                           rdy;
    logic [NRD-1:0][IDX_W-1:0]      rd_idx;
    logic [NRD-1:0][TAG_W-1:0]      rd_tag;
    logic [NRD-1:0][XLEN-1:0]       rd_val;
    logic                           ren_valid;
    logic [IDX_W-1:0]               ren_rd;
    logic [TAG_W-1:0]               ren_tag;
    logic [NCOMMIT-1:0]             cm_valid;
    logic [NCOMMIT-1:0][IDX_W-1:0]  cm_rd;
    logic [NCOMMIT-1:0][TAG_W-1:0]  cm_tag;
    logic [NCOMMIT-1:0][XLEN-1:0]   cm_val;
    logic                           ck_alloc;
    logic [CK_W-1:0]                ck_id;
    logic                           ck_full;
    logic                           ck_free;
    logic                           rec_valid;
    logic [CK_W-1:0]                rec_id;
    logic                           flush_all;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_rat dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .rd_idx    (rd_idx),
        .rd_tag    (rd_tag),
        .rd_val    (rd_val),
        .ren_valid (ren_valid),
        .ren_rd    (ren_rd),
        .ren_tag   (ren_tag),
        .cm_valid  (cm_valid),
        .cm_rd     (cm_rd),
        .cm_tag    (cm_tag),
        .cm_val    (cm_val),
        .ck_alloc  (ck_alloc),
        .ck_id     (ck_id),
        .ck_full   (ck_full),
        .ck_free   (ck_free),
        .rec_valid (rec_valid),
        .rec_id    (rec_id),
        .flush_all (flush_all)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_idx    = '0;
        ren_valid = 1'b0;
        ren_rd    = '0;
        ren_tag   = '0;
        cm_valid  = '0;
        cm_rd     = '0;
        cm_tag    = '0;
        cm_val    = '0;
        ck_alloc  = 1'b0;
        ck_free   = 1'b0;
        rec_valid = 1'b0;
        rec_id    = '0;
        flush_all = 1'b0;
    endtask

    task automatic rename(input int rd, input int tg);
        ren_valid = 1'b1;
        ren_rd    = IDX_W'(rd);
        ren_tag   = TAG_W'(tg);
    endtask

    task automatic commit(input int p, input int rd, input int tg, input logic [31:0] v);
        cm_valid[p] = 1'b1;
        cm_rd[p]    = IDX_W'(rd);
        cm_tag[p]   = TAG_W'(tg);
        cm_val[p]   = v;
    endtask

    // Read one register on port 1 and check value and tag.
    task automatic rd_chk(input string tag, input int idx, input logic [31:0] v, input int tg);
        rd_idx[1] = IDX_W'(idx);
        #1;
        chk({tag, "_val"}, rd_val[1], v);
        chk({tag, "_tag"}, 32'(rd_tag[1]), 32'(tg));
    endtask

    task automatic ck_chk(input string tag, input int id, input logic full);
        chk({tag, "_id"}, 32'(ck_id), 32'(id));
        chk({tag, "_full"}, 32'(ck_full), 32'(full));
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        ck_chk("reset_ck", 0, 1'b0);
        rd_chk("reset_x5", 5, 32'h0, 0);

        // Rename then commit with same-cycle bypass
        rename(5, 3);
        tick(); idle();
        rd_chk("ren_x5", 5, 32'h0, 3);
        commit(0, 5, 3, 32'hAA);
        rd_chk("byp_x5", 5, 32'hAA, 0);
        tick(); idle();
        rd_chk("cm_x5", 5, 32'hAA, 0);

        // Stale commit writes value but leaves younger tag
        rename(5, 3);
        tick();
        rename(5, 7);
        tick(); idle();
        commit(0, 5, 3, 32'h11);
        rd_chk("nobyp_x5", 5, 32'hAA, 7);
        tick(); idle();
        rd_chk("stale_x5", 5, 32'h11, 7);

        // Dual commit to the same register, port 1 is the live producer
        rename(9, 4);
        tick(); idle();
        commit(0, 9, 2, 32'h22);
        commit(1, 9, 4, 32'h44);
        rd_chk("dual_byp_x9", 9, 32'h44, 0);
        tick(); idle();
        rd_chk("dual_x9", 9, 32'h44, 0);

        // rdy low holds state; x0 is never renamed
        rdy = 1'b0;
        rename(10, 6);
        tick(); idle();
        rdy = 1'b1;
        rd_chk("hold_x10", 10, 32'h0, 0);
        rename(0, 3);
        commit(0, 0, 0, 32'hDEAD);
        tick(); idle();
        rd_chk("x0", 0, 32'h0, 0);

        // Checkpoint, commit clears inside snapshot, recover
        rename(1, 2);
        tick(); idle();
        ck_alloc = 1'b1;
        ck_chk("alloc0_pre", 0, 1'b0);
        tick(); idle();
        ck_chk("alloc0_post", 1, 1'b0);
        rename(1, 5);
        tick(); idle();
        commit(0, 1, 2, 32'h33);
        tick(); idle();
        rd_chk("live_x1", 1, 32'h33, 5);
        rec_valid = 1'b1;
        rec_id    = 2'd0;
        rename(2, 6);
        ck_alloc  = 1'b1;
        tick(); idle();
        rd_chk("rec_x1", 1, 32'h33, 0);
        rd_chk("rec_x2", 2, 32'h0, 0);
        rd_chk("rec_x5", 5, 32'h11, 7);
        ck_chk("rec_ck", 1, 1'b0);

        // Flush, then fill the checkpoint FIFO
        flush_all = 1'b1;
        tick(); idle();
        ck_chk("flush_ck", 0, 1'b0);
        rd_chk("flush_x5", 5, 32'h11, 0);
        for (int i = 0; i < 4; i++) begin
            ck_alloc = 1'b1;
            ck_chk("fill", i, 1'b0);
            tick(); idle();
        end
        ck_chk("full", 0, 1'b1);
        ck_alloc = 1'b1;
        tick(); idle();
        ck_chk("alloc_when_full", 0, 1'b1);
        ck_alloc = 1'b1;
        ck_free  = 1'b1;
        tick(); idle();
        ck_chk("alloc_free_full", 0, 1'b0);
        ck_alloc = 1'b1;
        tick(); idle();
        ck_chk("wrap_alloc", 1, 1'b1);
        ck_free = 1'b1;
        tick(); idle();
        ck_chk("free", 1, 1'b0);
        // head = 2: recovering to slot 3 leaves two live slots
        rec_valid = 1'b1;
        rec_id    = 2'd3;
        tick(); idle();
        ck_chk("rec3", 0, 1'b0);
        ck_alloc = 1'b1;
        tick(); idle();
        ck_chk("rec3_a1", 1, 1'b0);
        ck_alloc = 1'b1;
        tick(); idle();
        ck_chk("rec3_a2", 2, 1'b1);

        // flush_all beats recover and rename; commit value still lands
        rename(3, 6);
        tick();
        rename(4, 8);
        tick(); idle();
        flush_all = 1'b1;
        rec_valid = 1'b1;
        rec_id    = 2'd2;
        rename(7, 9);
        commit(0, 3, 6, 32'h55);
        tick(); idle();
        rd_chk("fl_x3", 3, 32'h55, 0);
        rd_chk("fl_x4", 4, 32'h0, 0);
        rd_chk("fl_x7", 7, 32'h0, 0);
        ck_chk("fl_ck", 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ck_alloc = 1'b1;
            tick(); idle();
        end
        ck_chk("fl_refill", 0, 1'b1);

        // Synchronous reset mid-operation
        rename(6, 5);
        tick(); idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ck_chk("rst2_ck", 0, 1'b0);
        rd_chk("rst2_x6", 6, 32'h0, 0);
        rd_chk("rst2_x3", 3, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_rat.md
# regfile_rat

Architectural register file with a rename (tag) table for the out-of-order core. Decode reads source operands through parametrised read ports and renames one destination per cycle. The ROB retires up to NCOMMIT results per cycle. Unlike a flush-all design, the block holds NCKPT in-order snapshots of the tag table, so a mispredicted branch restores only the state that was live at that branch. It sits between decode/dispatch and the ROB commit stage.

## Interface
- XLEN, 32: data width.
- NREG, 32: architectural registers; x0 is hard-wired to zero.
- TAG_W, 4: ROB tag width; tag 0 means "no producer, value is valid".
- NRD, 4: read ports.
- NCOMMIT, 2: commit ports; port 0 is the oldest.
- NCKPT, 4: checkpoint slots; must be a power of 2.
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- rdy in 1: global enable; when low, all state holds.
- rd_idx in NRD×log2(NREG): read register indices.
- rd_tag out NRD×TAG_W: producer tag, after commit bypass.
- rd_val out NRD×XLEN: register value, after commit bypass.
- ren_valid in 1, ren_rd in log2(NREG), ren_tag in TAG_W: destination rename.
- cm_valid in NCOMMIT, cm_rd in NCOMMIT×log2(NREG), cm_tag in NCOMMIT×TAG_W, cm_val in NCOMMIT×XLEN: retirement writes.
- ck_alloc in 1: take a snapshot this cycle. ck_id out log2(NCKPT): slot that will be used. ck_full out 1: no free slot.
- ck_free in 1: release the oldest slot (branch committed).
- rec_valid in 1, rec_id in log2(NCKPT): mispredict recovery to a slot.
- flush_all in 1: clear every tag and every checkpoint.

## Operation
- Reset:
  - All values 0, all tags 0, all checkpoints invalid.
  - Checkpoint head = tail = 0, count = 0.
  - Outputs ck_id = 0, ck_full = 0. rd_* reflect the reset table (0/0).
- Read (combinational):
  - Base result is value[idx] and tag[idx].
  - If any cm_valid[p] has cm_rd == idx ≠ 0 and cm_tag == tag[idx], output cm_val[p] and tag 0. If several ports match, the highest p wins.
  - idx = 0 always returns 0/0.
- Commit, per port in ascending order:
  - value[rd] ← val.
  - tag[rd] ← 0 only if tag[rd] == cm_tag.
  - Every valid checkpoint with ck[c][rd] == cm_tag also clears that entry to 0.
  - Writes to rd = 0 are ignored.
- Rename: tag[ren_rd] ← ren_tag when ren_valid, ren_rd ≠ 0 and ren_tag ≠ 0. Rename overrides any same-cycle commit clear of the same register.
- Checkpoint allocate:
  - Occurs when ck_alloc is high and ck_full is low.
  - Slot tail ← the post-update table of this cycle (commits, then rename).
  - tail++, count++. ck_id = tail.
  - ck_alloc while full is ignored; the producer must not issue it.
- Checkpoint free: when ck_free, head++ and count--. Freeing while empty is ignored.
- Recover (rec_valid):
  - tag table ← ck[rec_id], with that cycle's commits applied on top.
  - rename and ck_alloc are ignored that cycle.
  - tail ← rec_id + 1 (mod NCKPT), which discards all younger slots. count is recomputed.
  - A same-cycle ck_free is still honoured.
  - Values are never touched.
- flush_all:
  - All tags 0, head = tail = count = 0.
  - Takes precedence over rec_valid and rename.
  - Same-cycle commit value writes still occur.
- Priority when rdy = 1: rst > flush_all > rec_valid > normal update.

## Timing
- Reads: 0-cycle combinational, including the same-cycle commit bypass.
- All state updates are visible on the read ports one cycle after the clock edge.
- ck_full = (count == NCKPT) and ck_id are registered-state derived, so they are valid in the same cycle.
- Wrap-around: head and tail wrap modulo NCKPT. Full versus empty is distinguished by count.
- Simultaneous alloc and free when full: the free has no effect on the alloc in that cycle, so the alloc is rejected.
- Reset mid-operation discards all rename and checkpoint state.

## Structure
- Shared package holds:
  - The tag-zero constant.
  - Width macros for register index, tag and checkpoint id.
  - The flush priority encoding.
- One sub-module, rat_ckpt_store, holds the snapshot array, the head/tail/count FIFO logic, and the per-commit clear of checkpoint entries.
- The parent holds the value array, the live tag table and the read bypass.

## Test plan
- Reset, then read x5 → val 0, tag 0. Rename x5→tag 3, then commit x5 tag 3 value 0xAA → next-cycle read gives 0xAA/0.
- Rename x5→3, then x5→7. Commit tag 3 value 0x11 → value 0x11, tag stays 7. The same-cycle read of x5 during the commit shows tag 7 (no bypass).
- Same-cycle dual commit to x9 with tags 2 and 4, where the live tag is 4 → value from port 1, tag cleared.
- Rename x1→2, allocate (id 0), rename x1→5, then commit tag 2 → checkpoint 0 holds x1 tag 0. Recover to 0 → x1 tag 0, tail = 1.
- Allocate NCKPT times → ck_full = 1 and the next alloc is ignored. ck_free → ck_full = 0, and the next alloc id wraps to 0.
- flush_all together with rec_valid and commit x3 value 0x55 → all tags 0, x3 = 0x55, count = 0.
